embedded_cpuslave2_cpu_div_cell: RTL and testbench

EMBEDDED_CPUSLAVE2_CPU_DIV_CELL -- requirements
Module: Embedded_CPUSlave2_cpu_div_cell

---
 rtl/embedded_cpu_div_pkg.sv | 21 ++
 rtl/embedded_cpuslave2_cpu_div_step.sv | 24 ++
 rtl/embedded_cpuslave2_cpu_div_cell.sv | 139 +++++++++++++
 tb/tb_embedded_cpuslave2_cpu_div_cell.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/embedded_cpu_div_pkg.sv
// Shared definitions for the CPU slave divide cell: FSM encoding, default width
// and the fill patterns used for the divide-by-zero and signed-overflow results.
package embedded_cpu_div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

    // Divide by zero returns an all-ones quotient; overflow (most-negative / -1)
    // returns the most-negative quotient (MSB set, rest clear) and a zero remainder.
    localparam logic DIV_ZERO_QUOT_FILL = 1'b1;
    localparam logic OVF_QUOT_MSB       = 1'b1;
    localparam logic OVF_REM_FILL       = 1'b0;

endpackage

// File: rtl/embedded_cpuslave2_cpu_div_step.sv
// One restoring radix-2 division step: shift in the next dividend bit, trial-subtract
// the divisor on a WIDTH+1-bit datapath, keep the difference if it did not go negative.
module embedded_cpuslave2_cpu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] part_rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             quot_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted  = {part_rem, dividend_msb};
        diff     = shifted - {1'b0, divisor};
        quot_bit = ~diff[WIDTH];
        // Either branch is below the divisor, so the top bit is always zero here.
        next_rem = quot_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/embedded_cpuslave2_cpu_div_cell.sv
// Multi-cycle signed/unsigned integer divider for the CPU slave: one restoring step
// per cycle, result registered in FIX and announced by a one-cycle D_done pulse.
module embedded_cpuslave2_cpu_div_cell
    import embedded_cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    input  logic             E_div_start,
    input  logic             E_div_signed,
    input  logic             E_div_rem,
    input  logic             M_kill,
    output logic [WIDTH-1:0] D_result,
    output logic             D_busy,
    output logic             D_done
);

    localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {OVF_QUOT_MSB, {(WIDTH-1){1'b0}}};

    div_state_e       state;
    div_state_e       state_nxt;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] dvsr_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [CNT_W-1:0] cnt;
    logic             signed_reg;
    logic             rem_sel;
    logic             neg_quot;
    logic             neg_rem;
    logic             ovf;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] fix_quot;
    logic [WIDTH-1:0] fix_rem;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic negate);
        return negate ? -v : v;
    endfunction

    embedded_cpuslave2_cpu_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .part_rem    (rem_reg),
        .dividend_msb(quot_reg[WIDTH-1]),
        .divisor     (dvsr_reg),
        .next_rem    (step_rem),
        .quot_bit    (step_bit)
    );

    always_comb begin
        state_nxt = ST_IDLE;
        if (!M_kill) begin
            case (state)
                ST_IDLE, ST_DONE: state_nxt = E_div_start ? ST_PREP : ST_IDLE;
                ST_PREP:          state_nxt = ST_ITER;
                ST_ITER:          state_nxt = (cnt == '0) ? ST_FIX : ST_ITER;
                ST_FIX:           state_nxt = ST_DONE;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    // Sign fix-up; the zero-divisor and overflow overrides take priority.
    always_comb begin
        fix_quot = apply_sign(quot_reg, neg_quot);
        fix_rem  = apply_sign(rem_reg, neg_rem);
        if (dvsr_reg == '0) begin
            fix_quot = {WIDTH{DIV_ZERO_QUOT_FILL}};
        end else if (ovf) begin
            fix_quot = MOST_NEG;
            fix_rem  = {WIDTH{OVF_REM_FILL}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            quot_reg   <= '0;
            dvsr_reg   <= '0;
            rem_reg    <= '0;
            cnt        <= '0;
            signed_reg <= 1'b0;
            rem_sel    <= 1'b0;
            neg_quot   <= 1'b0;
            neg_rem    <= 1'b0;
            ovf        <= 1'b0;
            D_result   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (E_div_start && !M_kill) begin
                        quot_reg   <= E_src1;
                        dvsr_reg   <= E_src2;
                        signed_reg <= E_div_signed;
                        rem_sel    <= E_div_rem;
                    end
                end
                ST_PREP: begin
                    quot_reg <= magnitude(quot_reg, signed_reg);
                    dvsr_reg <= magnitude(dvsr_reg, signed_reg);
                    rem_reg  <= '0;
                    neg_quot <= signed_reg && (quot_reg[WIDTH-1] ^ dvsr_reg[WIDTH-1]);
                    neg_rem  <= signed_reg && quot_reg[WIDTH-1];
                    ovf      <= signed_reg && (quot_reg == MOST_NEG) && (dvsr_reg == '1);
                    cnt      <= CNT_LOAD;
                end
                ST_ITER: begin
                    rem_reg  <= step_rem;
                    quot_reg <= {quot_reg[WIDTH-2:0], step_bit};
                    cnt      <= cnt - CNT_ONE;
                end
                ST_FIX: begin
                    // A kill in FIX must leave the previous result visible.
                    if (!M_kill) begin
                        D_result <= rem_sel ? fix_rem : fix_quot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign D_busy = (state == ST_PREP) || (state == ST_ITER) || (state == ST_FIX);
    assign D_done = (state == ST_DONE);

endmodule

// File: tb/tb_embedded_cpuslave2_cpu_div_cell.sv
// Directed bench for the divide cell: latency, signed/unsigned results, corner
// cases, kill, ignored starts and asynchronous reset behaviour.
module tb_embedded_cpuslave2_cpu_div_cell;

    logic        clk;
    logic        reset_n;
    logic [31:0] E_src1;
    logic [31:0] E_src2;
    logic        E_div_start;
    logic        E_div_signed;
    logic        E_div_rem;
    logic        M_kill;
    logic [31:0] D_result;
    logic        D_busy;
    logic        D_done;

    int checks = 0;
    int errors = 0;

    embedded_cpuslave2_cpu_div_cell #(
        .WIDTH(32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .E_src1      (E_src1),
        .E_src2      (E_src2),
        .E_div_start (E_div_start),
        .E_div_signed(E_div_signed),
        .E_div_rem   (E_div_rem),
        .M_kill      (M_kill),
        .D_result    (D_result),
        .D_busy      (D_busy),
        .D_done      (D_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at posedge+1; returns at posedge+1 of the D_done cycle (or timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic rem, output logic [31:0] res, output int lat);
        E_src1 = a; E_src2 = b; E_div_signed = sgn; E_div_rem = rem; E_div_start = 1'b1;
        @(posedge clk); #1;
        E_div_start = 1'b0;
        E_src1 = 32'hDEADBEEF; E_src2 = 32'h0BADF00D;
        E_div_signed = ~sgn; E_div_rem = ~rem;
        lat = 0;
        while (!D_done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        res = D_result;
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (D_done) n++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; E_src1 = '0; E_src2 = '0; E_div_start = 0;
        E_div_signed = 0; E_div_rem = 0; M_kill = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (D_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected %h", D_result, 32'h0); end
        checks++; if (D_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", D_busy); end
        checks++; if (D_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", D_done); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        logic [31:0] r; int lat;
        run_op(32'd100, 32'd7, 1'b0, 1'b0, r, lat);
        checks++; if (lat !== 34) begin errors++; $display("FAIL uns_latency: got %0d expected 34", lat); end
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL uns_quot: got %h expected %h", r, 32'd14); end
        @(posedge clk); #1;
        checks++; if (D_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", D_done); end
        run_op(32'd100, 32'd7, 1'b0, 1'b1, r, lat);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL uns_rem: got %h expected %h", r, 32'd2); end
        run_op(32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, r, lat);
        checks++; if (r !== 32'h7FFFFFFC) begin errors++; $display("FAIL uns_big_quot: got %h expected %h", r, 32'h7FFFFFFC); end
    endtask

    task automatic test_signed;
        logic [31:0] r; int lat;
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, r, lat);
        checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL sgn_quot: got %h expected %h", r, 32'hFFFFFFFD); end
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, r, lat);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL sgn_rem: got %h expected %h", r, 32'hFFFFFFFF); end
        run_op(32'd50, 32'hFFFFFFF8, 1'b1, 1'b0, r, lat);
        checks++; if (r !== 32'hFFFFFFFA) begin errors++; $display("FAIL sgn_pos_neg_quot: got %h expected %h", r, 32'hFFFFFFFA); end
    endtask

    task automatic test_div_zero;
        logic [31:0] r; int lat;
        run_op(32'h12345678, 32'h0, 1'b0, 1'b0, r, lat);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_quot: got %h expected %h", r, 32'hFFFFFFFF); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL dz_latency: got %0d expected 34", lat); end
        run_op(32'h12345678, 32'h0, 1'b0, 1'b1, r, lat);
        checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL dz_rem: got %h expected %h", r, 32'h12345678); end
        run_op(32'hFFFFFFF9, 32'h0, 1'b1, 1'b0, r, lat);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_sgn_quot: got %h expected %h", r, 32'hFFFFFFFF); end
        run_op(32'hFFFFFFF9, 32'h0, 1'b1, 1'b1, r, lat);
        checks++; if (r !== 32'hFFFFFFF9) begin errors++; $display("FAIL dz_sgn_rem: got %h expected %h", r, 32'hFFFFFFF9); end
    endtask

    task automatic test_overflow;
        logic [31:0] r; int lat;
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, r, lat);
        checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL ovf_quot: got %h expected %h", r, 32'h80000000); end
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, r, lat);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL ovf_rem: got %h expected %h", r, 32'h0); end
    endtask

    task automatic test_kill;
        logic [31:0] r; int lat; int n;
        run_op(32'd100, 32'd7, 1'b0, 1'b1, r, lat);
        E_src1 = 32'd1000; E_src2 = 32'd3; E_div_signed = 0; E_div_rem = 0; E_div_start = 1;
        @(posedge clk); #1;
        E_div_start = 0;
        repeat (9) @(posedge clk);
        #1;
        M_kill = 1'b1;
        @(posedge clk); #1;
        M_kill = 1'b0;
        checks++; if (D_busy !== 1'b0) begin errors++; $display("FAIL kill_busy: got %b expected 0", D_busy); end
        checks++; if (D_result !== 32'd2) begin errors++; $display("FAIL kill_result_hold: got %h expected %h", D_result, 32'd2); end
        count_done(40, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL kill_no_done: got %0d pulses expected 0", n); end
        run_op(32'd1000, 32'd3, 1'b0, 1'b0, r, lat);
        checks++; if (r !== 32'd333 || lat !== 34) begin errors++; $display("FAIL after_kill_op: got %h lat %0d expected %h lat 34", r, lat, 32'd333); end
        // Kill and start together: the start is dropped.
        E_src1 = 32'd9; E_src2 = 32'd3; E_div_start = 1; M_kill = 1;
        @(posedge clk); #1;
        E_div_start = 0; M_kill = 0;
        checks++; if (D_busy !== 1'b0) begin errors++; $display("FAIL kill_start_busy: got %b expected 0", D_busy); end
        count_done(40, n);
        checks++; if (n !== 0 || D_result !== 32'd333) begin errors++; $display("FAIL kill_start_drop: got %0d pulses result %h expected 0 pulses result %h", n, D_result, 32'd333); end
    endtask

    task automatic test_busy_start;
        int lat; int n; logic held_ok; logic busy_ok;
        E_src1 = 32'd100; E_src2 = 32'd7; E_div_signed = 0; E_div_rem = 0; E_div_start = 1;
        @(posedge clk); #1;
        E_div_start = 0;
        lat = 0; held_ok = 1'b1; busy_ok = 1'b1;
        while (!D_done && lat < 60) begin
            if (lat == 4) begin
                E_src1 = 32'hFFFFFFFF; E_src2 = 32'd1; E_div_start = 1;
            end
            @(posedge clk); #1;
            E_div_start = 0;
            lat++;
            if (lat < 34 && D_result !== 32'd333) held_ok = 1'b0;
            if (lat < 34 && D_busy !== 1'b1) busy_ok = 1'b0;
        end
        checks++; if (!held_ok) begin errors++; $display("FAIL result_held_during_iter: got %b expected 1", held_ok); end
        checks++; if (!busy_ok) begin errors++; $display("FAIL busy_during_op: got %b expected 1", busy_ok); end
        checks++; if (lat !== 34 || D_result !== 32'd14) begin errors++; $display("FAIL busy_start_ignored: got %h lat %0d expected %h lat 34", D_result, lat, 32'd14); end
        count_done(40, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL busy_start_no_extra_done: got %0d expected 0", n); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r; int lat;
        run_op(32'hFFFFFFFF, 32'h10, 1'b0, 1'b0, r, lat);
        checks++; if (r !== 32'h0FFFFFFF) begin errors++; $display("FAIL b2b_first: got %h expected %h", r, 32'h0FFFFFFF); end
        run_op(32'd50, 32'hFFFFFFF8, 1'b1, 1'b1, r, lat);
        checks++; if (r !== 32'd2 || lat !== 34) begin errors++; $display("FAIL b2b_second: got %h lat %0d expected %h lat 34", r, lat, 32'd2); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r; int lat; int n;
        E_src1 = 32'd1000; E_src2 = 32'd3; E_div_signed = 0; E_div_rem = 0; E_div_start = 1;
        @(posedge clk); #1;
        E_div_start = 0;
        repeat (11) @(posedge clk);
        #1;
        E_div_start = 1;
        @(posedge clk); #1;
        E_div_start = 0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (D_result !== 32'h0) begin errors++; $display("FAIL async_reset_result: got %h expected %h", D_result, 32'h0); end
        checks++; if (D_busy !== 1'b0 || D_done !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got busy %b done %b expected 0 0", D_busy, D_done); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        count_done(50, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL reset_no_done: got %0d expected 0", n); end
        run_op(32'd100, 32'd7, 1'b0, 1'b1, r, lat);
        checks++; if (r !== 32'd2 || lat !== 34) begin errors++; $display("FAIL first_after_reset: got %h lat %0d expected %h lat 34", r, lat, 32'd2); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_kill();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
